key_pulse_gen: RTL

- Conditions the two raw push-button inputs (add, sub) before they reach the digit-setting modules.
- Synchronises and debounces each button, then emits one-clock-wide add_pulse / sub_pulse strobes.
- Auto-repeats strobes while a button is held, so a setter advances exactly one step per press or repeat tick.
- Sits between the board buttons and every per-digit setter; one instance is shared by all setters.

---
 rtl/key_pulse_gen_pkg.sv | 16 +
 rtl/key_debounce_repeat.sv | 123 ++++++++++++
 rtl/key_pulse_gen.sv | 58 +++++
 3 files changed

// File: rtl/key_pulse_gen_pkg.sv
// Shared types and default timing for the push-button pulse generator.
// FSM state encoding and 100 MHz debounce/repeat constants.
package key_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;
  localparam int DEF_CNT_W           = 26;

endpackage

// File: rtl/key_debounce_repeat.sv
// One button: 2-flop sync, debounce, press/auto-repeat FSM.
// Ports: clk, rst (sync, active-low), en, raw -> level, pulse.
module key_debounce_repeat
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'(REPEAT_PERIOD - 1);

  logic             sync_q1;
  logic             sync;
  logic             db;
  logic             db_nxt;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] dcnt_nxt;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_nxt;
  logic             pulse_q;
  logic             pulse_nxt;

  always_comb begin
    db_nxt   = db;
    dcnt_nxt = '0;
    if (sync != db) begin
      if (dcnt == DB_LAST) begin
        db_nxt = ~db;
      end else begin
        dcnt_nxt = dcnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
      db      <= 1'b0;
      dcnt    <= '0;
    end else begin
      sync_q1 <= raw;
      sync    <= sync_q1;
      db      <= db_nxt;
      dcnt    <= dcnt_nxt;
    end
  end

  // FSM follows db_nxt so the first pulse lands
  // in the same cycle the debounced level rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rcnt    <= '0;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      rcnt    <= rcnt_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!en || !db_nxt) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (!db) state_nxt = HOLD_WAIT;
        HOLD_WAIT:
          if (rcnt == DLY_LAST) state_nxt = REPEAT;
        REPEAT:
          state_nxt = REPEAT;
        default:
          state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pulse_nxt = 1'b0;
    rcnt_nxt  = '0;
    if (en && db_nxt) begin
      unique case (state)
        IDLE:
          pulse_nxt = ~db;
        HOLD_WAIT:
          if (rcnt == DLY_LAST) pulse_nxt = 1'b1;
          else rcnt_nxt = rcnt + ONE;
        REPEAT:
          if (rcnt == PER_LAST) pulse_nxt = 1'b1;
          else rcnt_nxt = rcnt + ONE;
        default: begin
          pulse_nxt = 1'b0;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign level = db;
  assign pulse = pulse_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Add/sub button conditioner: debounced levels and one-cycle steps.
// Ports: clk, rst, en, add_raw, sub_raw -> add/sub_pulse, add/sub_held.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic add_raw,
  input  logic sub_raw,
  output logic add_pulse,
  output logic sub_pulse,
  output logic add_held,
  output logic sub_held
);

  logic add_cand;
  logic sub_cand;

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_add (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .raw  (add_raw),
    .level(add_held),
    .pulse(add_cand)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) u_sub (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .raw  (sub_raw),
    .level(sub_held),
    .pulse(sub_cand)
  );

  // A candidate only survives while the other
  // button is released, so both can never fire.
  assign add_pulse = add_cand & en & ~sub_held;
  assign sub_pulse = sub_cand & en & ~add_held;

endmodule
